// File: rtl/sha512_core_inbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha512_core_inbuf_pkg
// Description : Shared constants and helpers for the per-core input block store.
// Revision    : 1.0 - initial release
// ============================================================================
package sha512_core_inbuf_pkg;

    localparam int c_BLK_OP_MSB    = 2;
    localparam int c_WORD_W        = 64;
    localparam int c_WORDS_PER_BLK = 16;
    localparam int c_WORD_AW       = $clog2(c_WORDS_PER_BLK);

    localparam logic [c_WORD_AW-1:0] c_LAST_WORD = c_WORD_AW'(c_WORDS_PER_BLK - 1);
    localparam logic [1:0]           c_CNT_FULL  = 2'd2;
    localparam logic [1:0]           c_CNT_EMPTY = 2'd0;

    // Occupancy update; a simultaneous commit and release leaves the count alone.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
        logic [1:0] res;
        res = cnt;
        case ({inc, dec})
            2'b10:   res = cnt + 2'd1;
            2'b01:   res = cnt - 2'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha512_core_inbuf_if.sv
`default_nettype none
// ============================================================================
// Module      : sha512_core_inbuf_if
// Description : Write, read and status signals between the distribution stage,
//               the input block store and its sha512 core.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha512_core_inbuf_if
    import sha512_core_inbuf_pkg::*;
#(
    parameter int WORD_W   = c_WORD_W,
    parameter int BLK_OP_W = c_BLK_OP_MSB + 1
);
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [WORD_W-1:0]    din;
    logic                 set_input_ready;
    logic                 input_ctx;
    logic                 input_seq;
    logic [BLK_OP_W-1:0]  input_blk_op;
    logic                 wr_rdy;
    logic [3:0]           rd_addr;
    logic                 rd_en;
    logic [WORD_W-1:0]    dout;
    logic                 blk_valid;
    logic                 blk_ctx;
    logic                 blk_seq;
    logic [BLK_OP_W-1:0]  blk_op;
    logic                 rd_done;
    logic                 err;

    modport master (
        output wr_en, wr_addr, din, set_input_ready, input_ctx, input_seq, input_blk_op,
        output rd_addr, rd_en, rd_done,
        input  wr_rdy, dout, blk_valid, blk_ctx, blk_seq, blk_op, err
    );

    modport slave (
        input  wr_en, wr_addr, din, set_input_ready, input_ctx, input_seq, input_blk_op,
        input  rd_addr, rd_en, rd_done,
        output wr_rdy, dout, blk_valid, blk_ctx, blk_seq, blk_op, err
    );

endinterface
`default_nettype wire

// File: rtl/sha512_inbuf_ram.sv
`default_nettype none
// ============================================================================
// Module      : sha512_inbuf_ram
// Description : Small RAM, one synchronous write port and one registered,
//               enable-gated read port with cleared output register.
// Revision    : 1.0 - initial release
// ============================================================================
module sha512_inbuf_ram #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 32
) (
    input  wire logic                       CLK,
    input  wire logic                       reset,
    input  wire logic                       we,
    input  wire logic [$clog2(DEPTH)-1:0]   waddr,
    input  wire logic [WORD_W-1:0]          wdata,
    input  wire logic                       re,
    input  wire logic [$clog2(DEPTH)-1:0]   raddr,
    output logic      [WORD_W-1:0]          rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    // Array has no reset so it can map onto distributed RAM.
    always_ff @(posedge CLK) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sha512_core_inbuf.sv
`default_nettype none
// ============================================================================
// Module      : sha512_core_inbuf
// Description : Per-core double-buffered SHA-512 input block store with
//               per-slot descriptors and a sticky protocol-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sha512_core_inbuf
    import sha512_core_inbuf_pkg::*;
#(
    parameter int WORD_W   = c_WORD_W,
    parameter int BLK_OP_W = c_BLK_OP_MSB + 1,
    parameter int N_SLOTS  = 2
) (
    input  wire logic          CLK,
    input  wire logic          reset,
    sha512_core_inbuf_if.slave bus
);

    if (N_SLOTS != 2) begin : g_slots_check
        $error("sha512_core_inbuf supports exactly two slots");
    end

    logic                 r_wr_slot;
    logic                 r_rd_slot;
    logic [1:0]           r_cnt;
    logic                 r_err;
    logic [N_SLOTS-1:0]   r_ctx;
    logic [N_SLOTS-1:0]   r_seq;
    logic [BLK_OP_W-1:0]  r_op [N_SLOTS];

    logic w_has_room;
    logic w_empty;
    logic w_wr_ok;
    logic w_commit;
    logic w_release;
    logic w_err_evt;

    assign w_has_room = (r_cnt != c_CNT_FULL);
    assign w_empty    = (r_cnt == c_CNT_EMPTY);
    assign w_wr_ok    = bus.wr_en & w_has_room;
    // set_input_ready is level-held upstream; only a qualified word may commit.
    assign w_commit   = w_wr_ok & bus.set_input_ready;
    assign w_release  = bus.rd_done & ~w_empty;

    assign w_err_evt  = (bus.wr_en & ~w_has_room)
                      | (w_commit & (bus.wr_addr != c_LAST_WORD))
                      | (bus.rd_en & w_empty)
                      | (bus.rd_done & w_empty);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_slot <= 1'b0;
            r_rd_slot <= 1'b0;
            r_cnt     <= c_CNT_EMPTY;
            r_err     <= 1'b0;
            r_ctx     <= '0;
            r_seq     <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                r_op[i] <= '0;
            end
        end else begin
            if (w_commit) begin
                r_ctx[r_wr_slot] <= bus.input_ctx;
                r_seq[r_wr_slot] <= bus.input_seq;
                r_op[r_wr_slot]  <= bus.input_blk_op;
                r_wr_slot        <= ~r_wr_slot;
            end
            if (w_release) begin
                r_rd_slot <= ~r_rd_slot;
            end
            r_cnt <= cnt_next(r_cnt, w_commit, w_release);
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    sha512_inbuf_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (N_SLOTS * c_WORDS_PER_BLK)
    ) u_ram (
        .CLK    (CLK),
        .reset  (reset),
        .we     (w_wr_ok),
        .waddr  ({r_wr_slot, bus.wr_addr}),
        .wdata  (bus.din),
        .re     (bus.rd_en),
        .raddr  ({r_rd_slot, bus.rd_addr}),
        .rdata  (bus.dout)
    );

    assign bus.wr_rdy    = w_has_room;
    assign bus.blk_valid = ~w_empty;
    assign bus.blk_ctx   = r_ctx[r_rd_slot];
    assign bus.blk_seq   = r_seq[r_rd_slot];
    assign bus.blk_op    = r_op[r_rd_slot];
    assign bus.err       = r_err;

endmodule
`default_nettype wire
